led_blink_multi: RTL and testbench
==================================

LED_BLINK_MULTI -- requirements
Module: led_blink_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent barrier/LED channels, at least 1.
REQ-002 SHALL have parameter PRESCALE, default 1: CLK cycles per phase step, at least 1.
REQ-003 SHALL have parameter PERIOD, default 4: phase steps per blink cycle, at least 2.
REQ-004 SHALL have parameter ON_STEPS, default 2: lit phase steps per blink cycle, in the range 0..PERIOD.
REQ-005 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port Barreira  input  CHANNELS  per-channel barrier sensor; 1 means blocked.
REQ-008 SHALL have port Modo  input  2  display mode: 00 off, 01 blink, 10 steady, 11 alternate.
REQ-009 SHALL have port LED  output  CHANNELS  per-channel LED drive.
REQ-010 SHALL have port Ativo  output  1  OR of all channel active flags.

Function
REQ-011 SHALL keep one shared prescaler counter that runs 0..PRESCALE-1 and wraps.
- Asserts internal tick in the cycle it equals PRESCALE-1.
- Free-running; barrier activity never resets it.
REQ-012 SHALL sample each Barreira bit into a registered active flag active_q[i] every cycle.
REQ-013 SHALL keep, per channel, a phase counter phase_q[i] of width clog2(PERIOD), range 0..PERIOD-1.
REQ-014 SHALL force phase_q[i] to 0 on every cycle where the sampled barrier is 0.
REQ-015 SHALL advance phase_q[i] by 1 on tick while active_q[i]=1 and the sampled barrier is 1, wrapping PERIOD-1 to 0.
REQ-016 SHALL decode LED[i] combinationally from registered state only, with LED[i]=0 whenever active_q[i]=0.
- Modo 00: LED[i]=0.
- Modo 01: LED[i]=(phase_q[i] < ON_STEPS).
- Modo 10: LED[i]=1.
- Modo 11: even i as mode 01; odd i gives the inverse of the mode 01 value, gated by active_q[i].
REQ-017 SHALL give one-cycle latency from a Barreira rising edge sampled at edge k to the LED high after edge k (mode 01 with ON_STEPS>0, or mode 10).
REQ-018 SHALL accept that the first phase step after activation lasts between 1 and PRESCALE cycles, since phase is aligned to the shared tick.
REQ-019 SHALL apply a Modo change in the same cycle to the LED decode without resetting any phase_q.
REQ-020 SHALL restart a channel at phase 0 when its barrier drops and returns, including a drop of a single cycle.
REQ-021 SHALL give ON_STEPS=0 an LED that is never lit in mode 01, and ON_STEPS=PERIOD an LED that is steady lit in mode 01.
REQ-022 SHALL keep channels fully independent, except for sharing the prescaler and Modo.

Reset
REQ-023 SHALL, while RST=1 at a rising CLK edge, clear the prescaler, every phase_q and every active_q to 0.
REQ-024 SHALL hold LED=0 and Ativo=0 in the cycle after a reset edge, regardless of Barreira and Modo.
REQ-025 SHALL let RST take priority over a tick or a barrier edge arriving in the same cycle.
REQ-026 SHALL, on RST asserted mid-blink, restart all channels from phase 0 once RST is released.

Configuration
REQ-027 SHALL, with macro BARREIRA_SYNC_EN defined, insert a two-flop synchronizer per Barreira bit ahead of the active_q sampling.
- Synchronizer flops cleared by RST.
- REQ-017 latency becomes 3 cycles.
- REQ-020 filtering is then measured on the synchronized signal.
REQ-028 SHALL, with BARREIRA_SYNC_EN undefined, sample Barreira directly with the latency of REQ-017.

Verification
REQ-029 SHALL cover the legacy pattern:
- Setup: CHANNELS=2, PRESCALE=1, PERIOD=4, ON_STEPS=2, Modo=01, Barreira=01 held.
- Required: LED[0] gives 1,1,0,0 repeating from the first active cycle; LED[1]=0; Ativo=1.
REQ-030 SHALL cover prescaling:
- Setup: PRESCALE=3, Barreira[0] high for 30 cycles.
- Required: each LED[0] level lasts 6 cycles, except the first phase step (1-3 cycles).
REQ-031 SHALL cover alternate mode:
- Setup: Modo=11, Barreira=11, PRESCALE=1.
- Required: LED[1] is always the complement of LED[0]; both go to 0 within 1 cycle of Barreira=00.
REQ-032 SHALL cover a barrier glitch:
- Setup: Barreira[0] drops for one cycle at phase 3.
- Required: LED[0] goes 0 that cycle, then restarts at phase 0 (lit).
REQ-033 SHALL cover reset mid-operation:
- Setup: RST=1 for one cycle during phase 1 with Modo=10.
- Required: LED=0 and Ativo=0 the next cycle, then relit one cycle after RST drops.
REQ-034 SHALL cover the synchronizer:
- Setup: BARREIRA_SYNC_EN defined.
- Required: LED[0] rises exactly 3 cycles after the Barreira[0] rising edge.

Source files
------------

// File: rtl/led_blink_multi.sv
// rtl/led_blink_multi.sv - multi-channel barrier-triggered LED blinker with shared prescaler.
// Optional BARREIRA_SYNC_EN adds a two-flop synchronizer on each Barreira bit.
module led_blink_multi #(
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 1,
  parameter int PERIOD   = 4,
  parameter int ON_STEPS = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] Barreira,
  input  logic [1:0]          Modo,
  output logic [CHANNELS-1:0] LED,
  output logic                Ativo
);

  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int PHW = $clog2(PERIOD);
  localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);
  localparam logic [PHW-1:0] PH_LAST = PHW'(PERIOD - 1);
  // one extra bit so ON_STEPS == PERIOD is representable
  localparam logic [PHW:0]   ON_LIM  = (PHW + 1)'(ON_STEPS);

  logic [PSW-1:0]      pre_cnt;
  logic                tick;
  logic [CHANNELS-1:0] bar_s;
  logic [CHANNELS-1:0] active_q;
  logic [PHW-1:0]      phase_q [CHANNELS];
  logic [CHANNELS-1:0] lit;

  assign tick = (pre_cnt == PS_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

`ifdef BARREIRA_SYNC_EN
  logic [CHANNELS-1:0] sync1, sync2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= Barreira;
      sync2 <= sync1;
    end
  end

  assign bar_s = sync2;
`else
  assign bar_s = Barreira;
`endif

  // A low barrier sample pins phase to 0, so a returning barrier always restarts lit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      active_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        phase_q[i] <= '0;
      end
    end else begin
      active_q <= bar_s;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!bar_s[i]) begin
          phase_q[i] <= '0;
        end else if (tick && active_q[i]) begin
          phase_q[i] <= (phase_q[i] == PH_LAST) ? '0 : phase_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    lit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      lit[i] = ({1'b0, phase_q[i]} < ON_LIM);
    end
  end

  always_comb begin
    LED = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (Modo)
        2'b01:   LED[i] = active_q[i] & lit[i];
        2'b10:   LED[i] = active_q[i];
        2'b11:   LED[i] = active_q[i] & (lit[i] ^ ((i % 2) == 1));
        default: LED[i] = 1'b0;
      endcase
    end
  end

  assign Ativo = |active_q;

endmodule

// File: tb/tb_led_blink_multi.sv
// tb/tb_led_blink_multi.sv - directed bench with a cycle-count model for four led_blink_multi configurations.
module tb_led_blink_multi;

  localparam int NC [4] = '{4, 2, 2, 2};
  localparam int PR [4] = '{1, 3, 1, 2};
  localparam int PE [4] = '{4, 4, 3, 2};
  localparam int ON [4] = '{2, 2, 3, 0};

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] Modo;
  logic [3:0] bar_v [4];

  logic [3:0] led_a;
  logic [1:0] led_b, led_c, led_d;
  logic       ativo_a, ativo_b, ativo_c, ativo_d;
  logic [3:0] led_v [4];
  logic [3:0] ativo_v;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  led_blink_multi #(.CHANNELS(4), .PRESCALE(1), .PERIOD(4), .ON_STEPS(2)) dut_a (
    .CLK(CLK), .RST(RST), .Barreira(bar_v[0]), .Modo(Modo), .LED(led_a), .Ativo(ativo_a));
  led_blink_multi #(.CHANNELS(2), .PRESCALE(3), .PERIOD(4), .ON_STEPS(2)) dut_b (
    .CLK(CLK), .RST(RST), .Barreira(bar_v[1][1:0]), .Modo(Modo), .LED(led_b), .Ativo(ativo_b));
  led_blink_multi #(.CHANNELS(2), .PRESCALE(1), .PERIOD(3), .ON_STEPS(3)) dut_c (
    .CLK(CLK), .RST(RST), .Barreira(bar_v[2][1:0]), .Modo(Modo), .LED(led_c), .Ativo(ativo_c));
  led_blink_multi #(.CHANNELS(2), .PRESCALE(2), .PERIOD(2), .ON_STEPS(0)) dut_d (
    .CLK(CLK), .RST(RST), .Barreira(bar_v[3][1:0]), .Modo(Modo), .LED(led_d), .Ativo(ativo_d));

  assign led_v[0] = led_a;
  assign led_v[1] = {2'b00, led_b};
  assign led_v[2] = {2'b00, led_c};
  assign led_v[3] = {2'b00, led_d};
  assign ativo_v  = {ativo_d, ativo_c, ativo_b, ativo_a};

  // Model: m counts clock edges since reset; the prescaler ticks on edges where m % P == 0,
  // so a channel activated at edge ma has taken m/P - ma/P phase steps.
  int   m = 0;
  bit   model_ok = 0;
  bit   act [4][4];
  int   ma  [4][4];
  logic [3:0] d1 [4];
  logic [3:0] d2 [4];
  logic [3:0] eff;

  always @(posedge CLK) begin
    if (RST) begin
      m = 0;
      model_ok = 1;
      for (int k = 0; k < 4; k++) begin
        d1[k] = '0;
        d2[k] = '0;
        for (int c = 0; c < 4; c++) act[k][c] = 0;
      end
    end else begin
      m++;
      for (int k = 0; k < 4; k++) begin
`ifdef BARREIRA_SYNC_EN
        eff = d2[k];
        d2[k] = d1[k];
        d1[k] = bar_v[k];
`else
        eff = bar_v[k];
`endif
        for (int c = 0; c < 4; c++) begin
          if (eff[c] && !act[k][c]) ma[k][c] = m;
          act[k][c] = eff[c];
        end
      end
    end
  end

  function automatic logic [3:0] exp_led(input int k);
    int   ph;
    logic on;
    exp_led = '0;
    for (int c = 0; c < NC[k]; c++) begin
      if (act[k][c]) begin
        ph = ((m / PR[k]) - (ma[k][c] / PR[k])) % PE[k];
        on = (ph < ON[k]);
        case (Modo)
          2'b01:   exp_led[c] = on;
          2'b10:   exp_led[c] = 1'b1;
          2'b11:   exp_led[c] = (c % 2 == 1) ? !on : on;
          default: exp_led[c] = 1'b0;
        endcase
      end
    end
  endfunction

  function automatic logic exp_ativo(input int k);
    exp_ativo = 1'b0;
    for (int c = 0; c < NC[k]; c++) exp_ativo = exp_ativo | act[k][c];
  endfunction

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (model_ok) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("model_led%0d", k), led_v[k], exp_led(k));
        chk($sformatf("model_ativo%0d", k), {3'b000, ativo_v[k]}, {3'b000, exp_ativo(k)});
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic s [30];
  int   runs [$];
  int   len;

  initial begin
    RST  = 1'b1;
    Modo = 2'b01;
    for (int k = 0; k < 4; k++) bar_v[k] = '0;
    step();
    step();
    chk("reset_led", led_a, 4'b0000);
    chk("reset_ativo", {3'b000, ativo_a}, 4'b0000);
    RST = 1'b0;
    step();

`ifdef BARREIRA_SYNC_EN
    bar_v[0] = 4'b0001;
    step(); chk("sync_lat1", led_a, 4'b0000);
    step(); chk("sync_lat2", led_a, 4'b0000);
    step(); chk("sync_lat3", led_a, 4'b0001);
    bar_v[1] = 4'b0011;
    bar_v[2] = 4'b0011;
    bar_v[3] = 4'b0011;
    repeat (20) step();
`else
    // legacy pattern: 1,1,0,0 from the first active cycle
    bar_v[0] = 4'b0001;
    for (int j = 0; j < 8; j++) begin
      step();
      chk("legacy_led", led_a, ((j % 4) < 2) ? 4'b0001 : 4'b0000);
      chk("legacy_ativo", {3'b000, ativo_a}, 4'b0001);
    end

    // one-cycle drop at phase 3
    bar_v[0] = 4'b0000;
    step(); chk("glitch_drop", led_a, 4'b0000);
    bar_v[0] = 4'b0001;
    step(); chk("glitch_restart0", led_a, 4'b0001);
    step(); chk("glitch_restart1", led_a, 4'b0001);
    step(); chk("glitch_restart2", led_a, 4'b0000);

    // alternate mode
    bar_v[0] = 4'b0000;
    step();
    Modo = 2'b11;
    bar_v[0] = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      step();
      chk("alt_led", led_a, ((j % 4) < 2) ? 4'b0101 : 4'b1010);
    end
    bar_v[0] = 4'b0000;
    step(); chk("alt_off", led_a, 4'b0000);

    // mode change keeps phase
    Modo = 2'b01;
    bar_v[0] = 4'b0001;
    step();
    step();
    Modo = 2'b10; #1; chk("mode_steady", led_a, 4'b0001);
    Modo = 2'b00; #1; chk("mode_off", led_a, 4'b0000);
    chk("mode_off_ativo", {3'b000, ativo_a}, 4'b0001);
    Modo = 2'b01; #1; chk("mode_blink_ph1", led_a, 4'b0001);
    step(); chk("mode_blink_ph2", led_a, 4'b0000);

    // reset mid-operation
    Modo = 2'b10;
    bar_v[0] = 4'b0011;
    step();
    step();
    RST = 1'b1;
    step();
    chk("midrst_led", led_a, 4'b0000);
    chk("midrst_ativo", {3'b000, ativo_a}, 4'b0000);
    RST = 1'b0;
    step(); chk("midrst_relit", led_a, 4'b0011);
    Modo = 2'b01; #1; chk("midrst_ph0", led_a, 4'b0011);
    step(); chk("midrst_ph1", led_a, 4'b0011);
    step(); chk("midrst_ph2", led_a, 4'b0000);
    bar_v[0] = 4'b0000;

    // prescaler: interior LED levels last 6 cycles
    bar_v[1] = 4'b0001;
    for (int j = 0; j < 30; j++) begin
      step();
      s[j] = led_b[0];
    end
    len = 1;
    for (int j = 1; j < 30; j++) begin
      if (s[j] == s[j-1]) len++;
      else begin
        runs.push_back(len);
        len = 1;
      end
    end
    chk("prescale_first_lit", {3'b000, s[0]}, 4'b0001);
    chk("prescale_first_len", {3'b000, (runs[0] >= 4 && runs[0] <= 6)}, 4'b0001);
    for (int r = 1; r < runs.size(); r++) chk("prescale_run", 4'(runs[r]), 4'd6);
    bar_v[1] = 4'b0000;

    // ON_STEPS == PERIOD steady, ON_STEPS == 0 dark
    bar_v[2] = 4'b0011;
    bar_v[3] = 4'b0011;
    for (int j = 0; j < 8; j++) begin
      step();
      chk("on_full", {2'b00, led_c}, 4'b0011);
      chk("on_zero", {2'b00, led_d}, 4'b0000);
    end
    Modo = 2'b10; #1; chk("on_zero_steady", {2'b00, led_d}, 4'b0011);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
